// File: rtl/serial_fs_controller.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// The result is only published on the DONE-entry edge; RUN accumulates privately.
module serial_fs_controller #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int IW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // One full-subtractor cell; returns {borrow_out, difference}.
   function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bi);
      logic d;
      logic bo;
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~(x ^ y) & bi);
      return {bo, d};
   endfunction

   state_t           state_r;
   state_t           state_nx_s;
   logic [IW-1:0]    idx_r;
   logic [WIDTH-1:0] opa_r;
   logic [WIDTH-1:0] opb_r;
   logic             brw_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] acc_nx_s;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;
   logic             busy_r;
   logic             done_r;
   logic [1:0]       cell_s;
   logic             last_s;

   assign cell_s     = fs_cell(opa_r[idx_r], opb_r[idx_r], brw_r);
   assign last_s     = (idx_r == IW'(WIDTH - 1));
   assign busy       = busy_r;
   assign done       = done_r;
   assign diff       = diff_r;
   assign borrow_out = bout_r;

   // Accumulator with the current bit merged in
   always_comb begin
      acc_nx_s        = acc_r;
      acc_nx_s[idx_r] = cell_s[0];
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nx_s = S_RUN;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (last_s) begin
               state_nx_s = S_DONE;
            end else begin
               state_nx_s = S_RUN;
            end
         end
         S_DONE:  state_nx_s = S_IDLE;
         default: state_nx_s = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Operand capture, serial datapath and registered status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_r  <= '0;
         opa_r  <= '0;
         opb_r  <= '0;
         brw_r  <= 1'b0;
         acc_r  <= '0;
         diff_r <= '0;
         bout_r <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_nx_s == S_RUN);
         done_r <= (state_nx_s == S_DONE);
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  opa_r <= a;
                  opb_r <= b;
                  brw_r <= borrow_in;
                  idx_r <= '0;
                  acc_r <= '0;
               end
            end
            S_RUN: begin
               acc_r <= acc_nx_s;
               brw_r <= cell_s[1];
               // Index saturates on the last bit so it never wraps
               if (last_s) begin
                  diff_r <= acc_nx_s;
                  bout_r <= cell_s[1];
               end else begin
                  idx_r <= idx_r + IW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_fs_controller.sv
// Directed and random checks of serial_fs_controller (WIDTH=8) against an
// arithmetic reference: diff = (a - b - bin) mod 256, borrow = (a < b + bin).
module tb_serial_fs_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       borrow_in;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow_out;

   int errs   = 0;
   int checks = 0;

   logic [7:0] held_diff;
   logic       held_bo;

   serial_fs_controller #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: plain; 1: change operands during RUN; 2: start during RUN and DONE
   task automatic do_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                        input logic xbin, input int mode);
      int         r;
      int         busy_cnt;
      bit         seen;
      logic [7:0] exp_d;
      logic       exp_bo;
      r      = int'(xa) - int'(xb) - int'(xbin);
      exp_d  = 8'(r & 255);
      exp_bo = (r < 0);
      @(negedge clk);
      a = xa; b = xb; borrow_in = xbin; start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      busy_cnt = 0;
      seen     = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         if (diff !== held_diff || borrow_out !== held_bo) begin
            chk({tag, "_hold_run"}, {23'd0, borrow_out, diff}, {23'd0, held_bo, held_diff});
         end
         start = 1'b0;
         if (mode == 1 && busy_cnt == 2) begin
            a = 8'hAA; b = 8'h55; borrow_in = ~xbin;
         end
         if (mode == 2 && busy_cnt == 3) begin
            a = 8'h00; b = 8'hFF; start = 1'b1;
         end
         @(negedge clk);
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
      chk({tag, "_diff"}, 32'(diff), 32'(exp_d));
      chk({tag, "_borrow"}, 32'(borrow_out), 32'(exp_bo));
      if (mode == 2) begin
         a = 8'h00; b = 8'hFF; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
      held_diff = exp_d;
      held_bo   = exp_bo;
      if (mode == 2) begin
         @(negedge clk);
         chk({tag, "_no_second"}, {30'd0, busy, done}, 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; borrow_in = 1'b0;
      held_diff = 8'h00; held_bo = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {22'd0, busy, done, borrow_out, diff}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_outs", {22'd0, busy, done, borrow_out, diff}, 32'd0);

      do_op("caseA", 8'h05, 8'h03, 1'b0, 0);
      do_op("caseB", 8'h03, 8'h05, 1'b0, 0);
      do_op("caseC", 8'h00, 8'h00, 1'b1, 0);
      do_op("caseD", 8'hFF, 8'h00, 1'b1, 0);
      do_op("busy_start", 8'h10, 8'h01, 1'b0, 2);
      do_op("opchange", 8'h37, 8'h12, 1'b1, 1);
      repeat (3) @(negedge clk);
      chk("idle_hold", {23'd0, borrow_out, diff}, {23'd0, held_bo, held_diff});

      // Reset during RUN cycle 4
      @(negedge clk);
      a = 8'h44; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_abort_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_outs", {22'd0, busy, done, borrow_out, diff}, 32'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) begin
            chk("abort_quiet", {30'd0, busy, done}, 32'd0);
         end
      end
      chk("abort_diff", {23'd0, borrow_out, diff}, 32'd0);
      held_diff = 8'h00; held_bo = 1'b0;
      do_op("post_reset", 8'h20, 8'h01, 1'b0, 0);

      for (int n = 0; n < 1000; n++) begin
         do_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/serial_fs_controller.md
SERIAL_FS_CONTROLLER -- requirements
Module: serial_fs_controller

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 borrow_in  input  1  initial borrow into bit 0; captured on the accepting edge.
REQ-008 busy  output  1  high while the block is in RUN.
REQ-009 done  output  1  one-cycle pulse, high only in DONE.
REQ-010 diff  output  WIDTH  result a - b - borrow_in, modulo 2^WIDTH.
REQ-011 borrow_out  output  1  final borrow out of bit WIDTH-1.

Function
REQ-012 The block SHALL compute the result bit-serially, LSB first, using one 1-bit full-subtractor cell: d = x ^ y ^ bi; bo = (~x & y) | (~(x ^ y) & bi).
REQ-013 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on an edge with start=1: latch a, b, borrow_in into internal registers; clear the bit index to 0; clear the internal result shift register.
REQ-015 IDLE with start=0 SHALL hold state; diff and borrow_out keep their last values.
REQ-016 In RUN, each edge SHALL process bit index i: write d into result bit i, load bo into the running borrow register, and increment i.
REQ-017 RUN -> DONE on the edge that processes bit WIDTH-1; RUN SHALL last exactly WIDTH cycles.
REQ-018 On entry to DONE, diff SHALL equal the full WIDTH-bit result and borrow_out SHALL equal the final bo.
REQ-019 DONE -> IDLE unconditionally on the next edge.
REQ-020 Latency: if start is accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH. Accept-to-accept minimum spacing is WIDTH+2 cycles.
REQ-021 start while in RUN or DONE SHALL be ignored, with no queuing. Changes on a, b and borrow_in after the accepting edge SHALL NOT affect the result.
REQ-022 diff and borrow_out SHALL update only on the DONE-entry edge and SHALL hold through IDLE until the next DONE.
REQ-023 Partial results SHALL NOT be visible on diff during RUN; internal accumulation uses a separate register.
REQ-024 The bit index SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap beyond WIDTH-1 within one operation.
REQ-025 borrow_out=1 SHALL indicate that {a} < {b} + borrow_in, treating operands as unsigned.

Reset
REQ-026 On an edge with rst_n=0, the FSM SHALL go to IDLE, with busy=0, done=0, diff=0, borrow_out=0, bit index=0, and internal operand, borrow and result registers cleared.
REQ-027 Reset SHALL take priority over start and over any in-progress RUN. An aborted operation SHALL produce no done pulse and SHALL leave diff and borrow_out at 0.
REQ-028 The first start after rst_n returns high SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 Case A: a=0x05, b=0x03, borrow_in=0, start pulse. Required response: busy high for 8 cycles, then done for 1 cycle, with diff=0x02 and borrow_out=0.
REQ-030 Case B: a=0x03, b=0x05, borrow_in=0. Required response: diff=0xFE, borrow_out=1. Case C: a=0x00, b=0x00, borrow_in=1. Required response: diff=0xFF, borrow_out=1. Case D: a=0xFF, b=0x00, borrow_in=1. Required response: diff=0xFE, borrow_out=0.
REQ-031 Start while busy: accept 0x10-0x01, then pulse start with a=0x00, b=0xFF at RUN cycle 3 and again during DONE. Required response: a single done with diff=0x0F and borrow_out=0, and no second operation.
REQ-032 Operand change: after acceptance, drive a=0xAA and b=0x55 during RUN. Required response: the result matches the operands latched at acceptance.
REQ-033 Reset mid-operation: assert rst_n=0 at RUN cycle 4 for 1 cycle. Required response: IDLE, busy=0, no done, and diff=0x00. A new start with 0x20-0x01 then gives diff=0x1F after exactly 8 RUN cycles.
REQ-034 Randomized: at least 1000 random a, b and borrow_in operations, each checked against the reference result (a - b - borrow_in) mod 256 and its borrow.
